// File: rtl/wei_loader_pkg.sv
// Shared types and default sizing for the weight shift-chain loader.
package wei_loader_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_PAR   = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } ld_state_e;

endpackage

// File: rtl/wei_sft_loader_if.sv
// Bus bundle between the register block side and the loader: config, word
// handshake, shift chain outputs and status.
interface wei_sft_loader_if #(
  parameter int DW    = wei_loader_pkg::DEF_DW,
  parameter int CNT_W = wei_loader_pkg::DEF_CNT_W
);
  logic             cfg_start;
  logic [CNT_W-1:0] cfg_word_num;
  logic             in_vld;
  logic [DW-1:0]    in_data;
  logic             in_rdy;
  logic             sft_en;
  logic             sft_dat;
  logic             sft_latch;
  logic [CNT_W-1:0] word_cnt;
  logic             sta_busy;
  logic             sta_done;
  logic             sta_ovf;

  modport master (
    output cfg_start, cfg_word_num, in_vld, in_data,
    input  in_rdy, sft_en, sft_dat, sft_latch, word_cnt,
           sta_busy, sta_done, sta_ovf
  );

  modport slave (
    input  cfg_start, cfg_word_num, in_vld, in_data,
    output in_rdy, sft_en, sft_dat, sft_latch, word_cnt,
           sta_busy, sta_done, sta_ovf
  );
endinterface

// File: rtl/wei_loader_fifo.sv
// Small synchronous word FIFO with wrap-around pointers, occupancy counter
// and a synchronous flush that takes priority over push/pop.
module wei_loader_fifo
  import wei_loader_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/wei_sft_loader.sv
// Buffers register-bus words and shifts them MSB-first onto the macro chain,
// latching each word and counting against a programmed frame length.
// Optional parity bit per word: define WEI_LOADER_PARITY_EN.
//
// state | meaning
// IDLE  | armed or not, waiting for a buffered word
// LOAD  | pop FIFO head into shift register
// SHIFT | one chain bit per cycle, MSB first
// PAR   | even-parity bit of the word (parity build only)
// LATCH | latch pulse, word counter increments
// DONE  | frame complete, hold until cfg_start
module wei_sft_loader
  import wei_loader_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  wei_sft_loader_if.slave bus
);
  localparam int BW = $clog2(DW);

  ld_state_e        state_q, state_d;
  logic [DW-1:0]    sreg_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             armed_q;
  logic             ovf_q;
  logic             in_rdy;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]    fifo_dout;
`ifdef WEI_LOADER_PARITY_EN
  logic             par_q;
`endif

  assign in_rdy    = armed_q && !fifo_full;
  assign fifo_push = bus.in_vld && in_rdy;
  assign cnt_inc   = word_cnt_q + CNT_W'(1);

  wei_loader_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.cfg_start),
    .push_i  (fifo_push),
    .din_i   (bus.in_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE:  if (armed_q && !fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        fifo_pop = 1'b1;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BW'(DW-1)) begin
`ifdef WEI_LOADER_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_LATCH;
`endif
        end
      end
      ST_PAR:   state_d = ST_LATCH;
      ST_LATCH: begin
        if (cnt_inc == len_q)  state_d = ST_DONE;
        else if (!fifo_empty)  state_d = ST_LOAD;
        else                   state_d = ST_IDLE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    // Restart wins from any state and aborts a word in flight.
    if (bus.cfg_start) begin
      fifo_pop = 1'b0;
      state_d  = (bus.cfg_word_num == '0) ? ST_DONE : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (bus.cfg_start) begin
      len_q      <= bus.cfg_word_num;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      bit_cnt_q  <= '0;
      armed_q    <= (bus.cfg_word_num != '0);
    end else begin
      if (bus.in_vld && !in_rdy) ovf_q <= 1'b1;
      case (state_q)
        ST_LOAD: begin
          sreg_q    <= fifo_dout;
          bit_cnt_q <= '0;
        end
        ST_SHIFT: begin
          sreg_q    <= {sreg_q[DW-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + BW'(1);
        end
        ST_LATCH: begin
          if (word_cnt_q != len_q) word_cnt_q <= cnt_inc;
          if (cnt_inc == len_q)    armed_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef WEI_LOADER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)                          par_q <= 1'b0;
    else if (state_q == ST_LOAD)      par_q <= ^fifo_dout;
  end

  assign bus.sft_en  = (state_q == ST_SHIFT) || (state_q == ST_PAR);
  assign bus.sft_dat = (state_q == ST_SHIFT) ? sreg_q[DW-1] :
                       (state_q == ST_PAR)   ? par_q : 1'b0;
`else
  assign bus.sft_en  = (state_q == ST_SHIFT);
  assign bus.sft_dat = (state_q == ST_SHIFT) ? sreg_q[DW-1] : 1'b0;
`endif

  assign bus.in_rdy    = in_rdy;
  assign bus.sft_latch = (state_q == ST_LATCH);
  assign bus.word_cnt  = word_cnt_q;
  assign bus.sta_busy  = armed_q;
  assign bus.sta_done  = (state_q == ST_DONE);
  assign bus.sta_ovf   = ovf_q;

endmodule

// File: tb/tb_wei_sft_loader.sv
// Directed scenarios with random words, checked against a bit-stream model.
module tb_wei_sft_loader;
  import wei_loader_pkg::*;

  localparam int DW = 16, DEPTH = 4, CNT_W = 8;
`ifdef WEI_LOADER_PARITY_EN
  localparam int WCOST = DW + 3;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int WCOST = DW + 2;
  localparam bit HAS_PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wei_sft_loader_if #(.DW(DW), .CNT_W(CNT_W)) bus ();
  wei_sft_loader #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  int en_total = 0;
  bit got_q[$];
  bit exp_q[$];
  int latch_cyc[$];
  bit stalled;
  int acc_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sft_en) begin
      got_q.push_back(bus.sft_dat);
      en_total++;
    end
    if (bus.sft_latch) latch_cyc.push_back(cyc);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_word(logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
    if (HAS_PAR) exp_q.push_back(^w);
  endtask

  task automatic start(int len);
    bus.cfg_start    = 1'b1;
    bus.cfg_word_num = CNT_W'(len);
    tick();
    bus.cfg_start    = 1'b0;
    got_q.delete();
    exp_q.delete();
    latch_cyc.delete();
  endtask

  // Producer that honours in_rdy: asserts in_vld only in cycles with in_rdy.
  task automatic send(logic [DW-1:0] w);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bus.in_rdy) begin
        bus.in_vld  = 1'b1;
        bus.in_data = w;
        acc_cyc     = cyc;
        tick();
        bus.in_vld  = 1'b0;
        ok = 1'b1;
        break;
      end
      stalled = 1'b1;
      tick();
    end
    chk("send_accept", ok, 1);
    add_word(w);
  endtask

  task automatic wait_done(output int seen);
    seen = -1;
    for (int k = 0; k < 2000; k++) begin
      if (bus.sta_done) begin
        seen = cyc;
        break;
      end
      tick();
    end
    chk("done_timeout", bus.sta_done, 1);
  endtask

  task automatic cmp_stream(string tag);
    int bad = 0;
    chk({tag, "_nbits"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_bits"}, bad, 0);
  endtask

  task automatic cmp_spacing(string tag);
    int bad = 0;
    for (int i = 1; i < latch_cyc.size(); i++)
      if (latch_cyc[i] - latch_cyc[i-1] != WCOST) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int seen, len, base;
    logic [DW-1:0] w;
    logic [DW-1:0] blast [6];

    bus.cfg_start = 0; bus.cfg_word_num = '0; bus.in_vld = 0; bus.in_data = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_sft_en", bus.sft_en, 0);
    chk("rst_sft_dat", bus.sft_dat, 0);
    chk("rst_latch", bus.sft_latch, 0);
    chk("rst_word_cnt", bus.word_cnt, 0);
    chk("rst_busy", bus.sta_busy, 0);
    chk("rst_done", bus.sta_done, 0);
    chk("rst_ovf", bus.sta_ovf, 0);
    rst = 1'b0;
    tick();

    // Single word with latency checks
    start(1);
    chk("sw_in_rdy", bus.in_rdy, 1);
    chk("sw_busy", bus.sta_busy, 1);
    send(16'hA5C3);
    wait_done(seen);
    cmp_stream("sw");
    chk("sw_nlatch", latch_cyc.size(), 1);
    if (latch_cyc.size() > 0) begin
      chk("sw_latency", latch_cyc[0] - acc_cyc, WCOST + 1);
      chk("sw_done_edge", seen - latch_cyc[0], 1);
    end
    chk("sw_word_cnt", bus.word_cnt, 1);
    chk("sw_busy_end", bus.sta_busy, 0);
    chk("sw_ovf", bus.sta_ovf, 0);

    // Burst with backpressure, words 1..6
    start(6);
    stalled = 1'b0;
    for (int i = 1; i <= 6; i++) send(DW'(i));
    chk("burst_stall_seen", stalled, 1);
    wait_done(seen);
    cmp_stream("burst");
    chk("burst_nlatch", latch_cyc.size(), 6);
    cmp_spacing("burst_spacing");
    chk("burst_word_cnt", bus.word_cnt, 6);
    chk("burst_ovf", bus.sta_ovf, 0);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(2, 7);
      start(len);
      for (int i = 0; i < len; i++) send(DW'($urandom));
      wait_done(seen);
      cmp_stream("rnd");
      chk("rnd_nlatch", latch_cyc.size(), len);
      cmp_spacing("rnd_spacing");
      chk("rnd_word_cnt", bus.word_cnt, len);
      chk("rnd_ovf", bus.sta_ovf, 0);
    end

    // Overflow: six back-to-back strobes ignoring in_rdy; the sixth lands on a full FIFO
    start(8);
    for (int i = 0; i < 6; i++) blast[i] = DW'($urandom);
    for (int i = 0; i < 6; i++) begin
      bus.in_vld = 1'b1;
      bus.in_data = blast[i];
      tick();
    end
    bus.in_vld = 1'b0;
    for (int i = 0; i < 5; i++) add_word(blast[i]);
    chk("ovf_set", bus.sta_ovf, 1);
    for (int i = 0; i < 3; i++) send(DW'($urandom));
    wait_done(seen);
    cmp_stream("ovf");
    chk("ovf_word_cnt", bus.word_cnt, 8);
    chk("ovf_sticky", bus.sta_ovf, 1);

    // Zero length, then a push while DONE
    start(0);
    chk("zero_done", bus.sta_done, 1);
    chk("zero_busy", bus.sta_busy, 0);
    chk("zero_ovf_clr", bus.sta_ovf, 0);
    chk("zero_in_rdy", bus.in_rdy, 0);
    base = en_total;
    repeat (20) tick();
    chk("zero_no_shift", en_total - base, 0);
    bus.in_vld = 1'b1;
    bus.in_data = 16'h1234;
    tick();
    bus.in_vld = 1'b0;
    tick();
    chk("done_push_ovf", bus.sta_ovf, 1);
    chk("done_push_cnt", bus.word_cnt, 0);
    chk("done_push_noshift", en_total - base, 0);

    // Restart during the 8th SHIFT cycle of word 2 of 4
    start(4);
    for (int i = 0; i < 4; i++) send(DW'($urandom));
    for (int k = 0; k < 200 && latch_cyc.size() == 0; k++) tick();
    chk("rs_first_latch", latch_cyc.size(), 1);
    repeat (8) tick();
    bus.cfg_start = 1'b1;
    bus.cfg_word_num = CNT_W'(2);
    tick();
    bus.cfg_start = 1'b0;
    chk("rs_bits_before", got_q.size(), WCOST - 2 + 8);
    chk("rs_word_cnt", bus.word_cnt, 0);
    chk("rs_busy", bus.sta_busy, 1);
    chk("rs_in_rdy", bus.in_rdy, 1);
    base = en_total;
    repeat (25) tick();
    chk("rs_no_latch", latch_cyc.size(), 1);
    chk("rs_fifo_empty", en_total - base, 0);
    got_q.delete(); exp_q.delete(); latch_cyc.delete();
    for (int i = 0; i < 2; i++) send(DW'($urandom));
    wait_done(seen);
    cmp_stream("rs_new");
    chk("rs_new_cnt", bus.word_cnt, 2);
    chk("rs_new_nlatch", latch_cyc.size(), 2);

    // Parity-sensitive word 0x0007: last chain bit of the word
    start(1);
    send(16'h0007);
    wait_done(seen);
    cmp_stream("w7");
    if (got_q.size() > 0) chk("w7_last_bit", got_q[got_q.size()-1], HAS_PAR ? 1 : 1);

    // Reset asserted mid-SHIFT
    start(2);
    base = en_total;
    send(DW'($urandom));
    for (int k = 0; k < 50 && en_total - base < 4; k++) tick();
    chk("mid_rst_shifting", bus.sft_en, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_sft_en", bus.sft_en, 0);
    chk("mid_rst_sft_dat", bus.sft_dat, 0);
    chk("mid_rst_latch", bus.sft_latch, 0);
    chk("mid_rst_cnt", bus.word_cnt, 0);
    chk("mid_rst_busy", bus.sta_busy, 0);
    chk("mid_rst_in_rdy", bus.in_rdy, 0);
    rst = 1'b0;
    base = en_total;
    repeat (10) tick();
    chk("post_rst_idle", en_total - base, 0);
    chk("post_rst_done", bus.sta_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
